// File: rtl/striping_lane_scheduler_if.sv
// Lane-side and stream-side signals of the 2-lane -> 1-stream striping scheduler.
interface striping_lane_scheduler_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] lane_0;
  logic              valid_0;
  logic [DATA_W-1:0] lane_1;
  logic              valid_1;
  logic              clr_err;
  logic [DATA_W-1:0] data_output;
  logic              valid_out;
  logic              ready_0;
  logic              ready_1;
  logic              sel;
  logic [1:0]        state;
  logic              overflow_err;

  // Producer / consumer side (drives lanes, watches the stream)
  modport master (
    output lane_0, valid_0, lane_1, valid_1, clr_err,
    input  data_output, valid_out, ready_0, ready_1, sel, state, overflow_err
  );

  // Scheduler side
  modport slave (
    input  lane_0, valid_0, lane_1, valid_1, clr_err,
    output data_output, valid_out, ready_0, ready_1, sel, state, overflow_err
  );
endinterface

// File: rtl/striping_lane_scheduler.sv
// Striping scheduler: buffers two skewed lanes in small FIFOs and emits them as
// one stream in strict 0,1,0,1 order; stalls, times out to IDLE on starvation,
// and parks in ERR on FIFO overflow until clr_err.
module striping_lane_scheduler #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned STALL_MAX = 8
) (
  input  logic                    clk_2f,
  input  logic                    reset,
  striping_lane_scheduler_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned STL_W = $clog2(STALL_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_mem0 [DEPTH];
  logic [DATA_W-1:0]   r_mem1 [DEPTH];
  logic [PTR_W-1:0]    r_rd0, r_wr0, r_rd1, r_wr1;
  logic [CNT_W-1:0]    r_cnt0, r_cnt1, w_cnt0_nxt, w_cnt1_nxt;
  logic [STL_W-1:0]    r_stall, w_stall_nxt, w_stall_inc;
  logic                r_sel, w_sel_nxt;
  logic                r_valid_out, w_valid_nxt;
  logic [DATA_W-1:0]   r_data, w_data_nxt;
  logic                r_ovf, w_ovf_nxt;
  logic                w_full0, w_full1, w_empty0, w_empty1;
  logic                w_pop0, w_pop1, w_wr0, w_wr1, w_ovf, w_flush;

  // FIFO status, pop/push qualification; a full FIFO still accepts when it pops
  always_comb begin
    w_full0     = (r_cnt0 == CNT_W'(DEPTH));
    w_full1     = (r_cnt1 == CNT_W'(DEPTH));
    w_empty0    = (r_cnt0 == '0);
    w_empty1    = (r_cnt1 == '0);
    w_pop0      = (r_state == S_RUN) && !r_sel && !w_empty0;
    w_pop1      = (r_state == S_RUN) &&  r_sel && !w_empty1;
    w_wr0       = bus.valid_0 && (!w_full0 || w_pop0);
    w_wr1       = bus.valid_1 && (!w_full1 || w_pop1);
    w_ovf       = (bus.valid_0 && !w_wr0) || (bus.valid_1 && !w_wr1);
    w_cnt0_nxt  = r_cnt0 + CNT_W'(w_wr0) - CNT_W'(w_pop0);
    w_cnt1_nxt  = r_cnt1 + CNT_W'(w_wr1) - CNT_W'(w_pop1);
    w_stall_inc = r_stall + STL_W'(1);
  end

  // Next-state and output decode; overflow beats timeout, clr_err only acts in ERR
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_stall_nxt = r_stall;
    w_valid_nxt = 1'b0;
    w_data_nxt  = r_data;
    w_ovf_nxt   = r_ovf | w_ovf;
    w_flush     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_ovf) begin
          w_state_nxt = S_ERR;
        end else if (!w_empty0 && !w_empty1) begin
          w_state_nxt = S_RUN;
          w_sel_nxt   = 1'b0;
          w_stall_nxt = '0;
        end
      end
      S_RUN: begin
        if (w_pop0 || w_pop1) begin
          w_data_nxt  = w_pop0 ? r_mem0[r_rd0] : r_mem1[r_rd1];
          w_valid_nxt = 1'b1;
          w_sel_nxt   = ~r_sel;
          w_stall_nxt = '0;
        end else begin
          w_stall_nxt = w_stall_inc;
        end
        if (w_ovf) begin
          w_state_nxt = S_ERR;
          w_stall_nxt = '0;
        end else if (!(w_pop0 || w_pop1) && (w_stall_inc == STL_W'(STALL_MAX))) begin
          w_state_nxt = S_IDLE;
          w_flush     = 1'b1;
          w_sel_nxt   = 1'b0;
          w_stall_nxt = '0;
        end
      end
      S_ERR: begin
        if (bus.clr_err) begin
          w_state_nxt = S_IDLE;
          w_flush     = 1'b1;
          w_ovf_nxt   = 1'b0;
          w_sel_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_flush     = 1'b1;
        w_sel_nxt   = 1'b0;
        w_stall_nxt = '0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FIFO bookkeeping and registered stream outputs
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      r_rd0       <= '0;
      r_wr0       <= '0;
      r_cnt0      <= '0;
      r_rd1       <= '0;
      r_wr1       <= '0;
      r_cnt1      <= '0;
      r_stall     <= '0;
      r_sel       <= 1'b0;
      r_valid_out <= 1'b0;
      r_data      <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_stall     <= w_stall_nxt;
      r_sel       <= w_sel_nxt;
      r_valid_out <= w_valid_nxt;
      r_data      <= w_data_nxt;
      r_ovf       <= w_ovf_nxt;
      if (w_flush) begin
        r_rd0  <= '0;
        r_wr0  <= '0;
        r_cnt0 <= '0;
        r_rd1  <= '0;
        r_wr1  <= '0;
        r_cnt1 <= '0;
      end else begin
        if (w_wr0)  r_wr0 <= r_wr0 + PTR_W'(1);
        if (w_pop0) r_rd0 <= r_rd0 + PTR_W'(1);
        if (w_wr1)  r_wr1 <= r_wr1 + PTR_W'(1);
        if (w_pop1) r_rd1 <= r_rd1 + PTR_W'(1);
        r_cnt0 <= w_cnt0_nxt;
        r_cnt1 <= w_cnt1_nxt;
      end
    end
  end

  // Lane storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk_2f) begin
    if (w_wr0) r_mem0[r_wr0] <= bus.lane_0;
    if (w_wr1) r_mem1[r_wr1] <= bus.lane_1;
  end

  assign bus.data_output  = r_data;
  assign bus.valid_out    = r_valid_out;
  assign bus.ready_0      = !w_full0;
  assign bus.ready_1      = !w_full1;
  assign bus.sel          = r_sel;
  assign bus.state        = r_state;
  assign bus.overflow_err = r_ovf;
endmodule

// File: tb/tb_striping_lane_scheduler.sv
// Directed bench for striping_lane_scheduler: in-order stream, skew, starvation
// timeout, overflow/clear, async reset mid-run, push+pop on a full FIFO.
module tb_striping_lane_scheduler;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned STALL_MAX = 8;

  logic        clk_2f = 1'b0;
  logic        reset  = 1'b1;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  striping_lane_scheduler_if #(.DATA_W(DATA_W)) bus();

  striping_lane_scheduler #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .STALL_MAX(STALL_MAX)
  ) dut (
    .clk_2f(clk_2f),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_2f = ~clk_2f;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [31:0] d0, input logic v1, input logic [31:0] d1);
    bus.valid_0 = v0;
    bus.lane_0  = d0;
    bus.valid_1 = v1;
    bus.lane_1  = d1;
  endtask

  // One clock edge, then sample; every valid output word is logged
  task automatic step();
    @(posedge clk_2f);
    #1;
    if (bus.valid_out === 1'b1) got_q.push_back(bus.data_output);
  endtask

  task automatic check_stream(input string tag);
    check_eq({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq(tag, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.clr_err = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0);

    // ---- 1: reset values, basic stream and first-word latency
    repeat (2) @(posedge clk_2f);
    #1;
    check_eq("rst_state", 32'(bus.state), 32'd0);
    check_eq("rst_valid", 32'(bus.valid_out), 32'd0);
    check_eq("rst_data", bus.data_output, 32'h0);
    check_eq("rst_sel", 32'(bus.sel), 32'd0);
    check_eq("rst_ovf", 32'(bus.overflow_err), 32'd0);
    check_eq("rst_ready0", 32'(bus.ready_0), 32'd1);
    check_eq("rst_ready1", 32'(bus.ready_1), 32'd1);
    reset = 1'b0;
    drive(1'b1, 32'hAAAAAAAA, 1'b1, 32'hEEEEEEEE);
    step();
    check_eq("t1_k_state", 32'(bus.state), 32'd0);
    check_eq("t1_k_valid", 32'(bus.valid_out), 32'd0);
    drive(1'b1, 32'hCCCCCCCC, 1'b1, 32'hAAAAAAAA);
    step();
    check_eq("t1_k1_state", 32'(bus.state), 32'd1);
    check_eq("t1_k1_valid", 32'(bus.valid_out), 32'd0);
    drive(1'b1, 32'h11111111, 1'b1, 32'h99999999);
    step();
    check_eq("t1_k2_valid", 32'(bus.valid_out), 32'd1);
    check_eq("t1_k2_data", bus.data_output, 32'hAAAAAAAA);
    check_eq("t1_k2_sel", 32'(bus.sel), 32'd1);
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    repeat (5) step();
    exp_q = '{32'hAAAAAAAA, 32'hEEEEEEEE, 32'hCCCCCCCC,
              32'hAAAAAAAA, 32'h11111111, 32'h99999999};
    check_stream("t1_stream");
    repeat (7) step();
    check_eq("t1_stall7_state", 32'(bus.state), 32'd1);
    check_eq("t1_stall_hold", bus.data_output, 32'h99999999);
    step();
    check_eq("t1_timeout_state", 32'(bus.state), 32'd0);

    // ---- 2: lane 1 skewed two cycles behind lane 0
    for (int c = 0; c < 14; c++) begin
      drive(c < 4, 32'(32'h20000000 + c), (c >= 2) && (c < 6), 32'(32'h21000000 + c - 2));
      step();
      if (c == 2) check_eq("t2_idle_wait", 32'(bus.state), 32'd0);
      if (c == 3) check_eq("t2_run_entry", 32'(bus.state), 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'(32'h20000000 + i));
      exp_q.push_back(32'(32'h21000000 + i));
    end
    check_stream("t2_stream");
    check_eq("t2_ovf", 32'(bus.overflow_err), 32'd0);
    repeat (6) step();
    check_eq("t2_timeout_state", 32'(bus.state), 32'd0);

    // ---- 3: lane 1 starves after one word; timeout flushes leftover X2
    drive(1'b1, 32'h30000000, 1'b1, 32'h31000000);
    step();
    drive(1'b1, 32'h30000001, 1'b0, 32'h0);
    step();
    check_eq("t3_run", 32'(bus.state), 32'd1);
    drive(1'b1, 32'h30000002, 1'b0, 32'h0);
    step();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    repeat (3) step();
    check_eq("t3_stall_valid", 32'(bus.valid_out), 32'd0);
    check_eq("t3_stall_hold", bus.data_output, 32'h30000001);
    repeat (6) step();
    check_eq("t3_stall7_state", 32'(bus.state), 32'd1);
    step();
    check_eq("t3_timeout_state", 32'(bus.state), 32'd0);
    check_eq("t3_ready0", 32'(bus.ready_0), 32'd1);
    check_eq("t3_ready1", 32'(bus.ready_1), 32'd1);
    check_eq("t3_valid", 32'(bus.valid_out), 32'd0);
    exp_q = '{32'h30000000, 32'h31000000, 32'h30000001};
    check_stream("t3_stream");
    drive(1'b1, 32'h3A000000, 1'b1, 32'h3B000000);
    step();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    repeat (3) step();
    exp_q = '{32'h3A000000, 32'h3B000000};
    check_stream("t3_after_flush");
    repeat (8) step();
    check_eq("t3_idle_again", 32'(bus.state), 32'd0);

    // ---- 4: overflow on lane 0, then clear
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'(32'h40000000 + i), 1'b0, 32'h0);
      step();
      if (i == 2) check_eq("t4_ready0_w3", 32'(bus.ready_0), 32'd1);
      if (i == 3) begin
        check_eq("t4_ready0_w4", 32'(bus.ready_0), 32'd0);
        check_eq("t4_ovf_w4", 32'(bus.overflow_err), 32'd0);
        check_eq("t4_state_w4", 32'(bus.state), 32'd0);
      end
    end
    check_eq("t4_ovf", 32'(bus.overflow_err), 32'd1);
    check_eq("t4_err_state", 32'(bus.state), 32'd2);
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    step();
    check_eq("t4_err_hold", 32'(bus.state), 32'd2);
    check_eq("t4_err_valid", 32'(bus.valid_out), 32'd0);
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    check_eq("t4_clr_state", 32'(bus.state), 32'd0);
    check_eq("t4_clr_ovf", 32'(bus.overflow_err), 32'd0);
    check_eq("t4_clr_ready0", 32'(bus.ready_0), 32'd1);

    // ---- 5: asynchronous reset mid-RUN
    drive(1'b1, 32'h50000000, 1'b1, 32'h51000000);
    step();
    drive(1'b1, 32'h50000001, 1'b1, 32'h51000001);
    step();
    drive(1'b1, 32'h50000002, 1'b1, 32'h51000002);
    step();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    step();
    check_eq("t5_pre_valid", 32'(bus.valid_out), 32'd1);
    exp_q = '{32'h50000000, 32'h51000000};
    check_stream("t5_pre_stream");
    #2;
    reset = 1'b1;
    #1;
    check_eq("t5_rst_valid", 32'(bus.valid_out), 32'd0);
    check_eq("t5_rst_data", bus.data_output, 32'h0);
    check_eq("t5_rst_state", 32'(bus.state), 32'd0);
    check_eq("t5_rst_sel", 32'(bus.sel), 32'd0);
    check_eq("t5_rst_ready0", 32'(bus.ready_0), 32'd1);
    check_eq("t5_rst_ready1", 32'(bus.ready_1), 32'd1);
    @(posedge clk_2f);
    #1;
    reset = 1'b0;
    drive(1'b1, 32'h5A000000, 1'b1, 32'h5B000000);
    step();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    repeat (3) step();
    exp_q = '{32'h5A000000, 32'h5B000000};
    check_stream("t5_restart");
    repeat (8) step();
    check_eq("t5_idle_again", 32'(bus.state), 32'd0);

    // ---- 6: push and pop on a full lane-0 FIFO in the same cycle
    drive(1'b1, 32'h60000000, 1'b1, 32'h61000000);
    step();
    for (int i = 1; i < 6; i++) begin
      drive(1'b1, 32'(32'h60000000 + i), 1'b0, 32'h0);
      step();
    end
    check_eq("t6_full_ready0", 32'(bus.ready_0), 32'd0);
    drive(1'b0, 32'h0, 1'b1, 32'h61000001);
    step();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    step();
    drive(1'b1, 32'h60000006, 1'b1, 32'h61000002);
    step();
    check_eq("t6_pushpop_ready0", 32'(bus.ready_0), 32'd0);
    check_eq("t6_pushpop_ovf", 32'(bus.overflow_err), 32'd0);
    check_eq("t6_pushpop_state", 32'(bus.state), 32'd1);
    for (int i = 3; i < 8; i++) begin
      drive(1'b0, 32'h0, 1'b1, 32'(32'h61000000 + i));
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    repeat (4) step();
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(32'(32'h60000000 + i));
      exp_q.push_back(32'(32'h61000000 + i));
    end
    check_stream("t6_stream");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
